// File: rtl/fifo_rd_sched_pkg.sv
// fifo_rd_sched_pkg
//   Shared types and defaults for the FIFO read-side scheduler.
//   N_CH / CH_W       : channel count and channel-index width
//   DAT_W             : FIFO word width
//   *_DEF             : default burst length and output buffer depth
package fifo_rd_sched_pkg;

  localparam int unsigned N_CH           = 8;
  localparam int unsigned CH_W           = 3;
  localparam int unsigned DAT_W          = 36;
  localparam int unsigned BURST_LEN_DEF  = 8;
  localparam int unsigned OBUF_DEPTH_DEF = 4;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  // Tags that accompany a read while its data is in flight.
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            first;
  } rd_tag_t;

  // One output buffer entry.
  typedef struct packed {
    logic [DAT_W-1:0] dat;
    logic [CH_W-1:0]  ch;
    logic             first;
  } obuf_ent_t;

endpackage

// File: rtl/fifo_rd_sched_if.sv
// fifo_rd_sched_if
//   Valid/ready output stream of the read scheduler.
//   out_dat_o   : data word            out_ch_o    : source channel
//   out_first_o : first word of burst  out_valid_o : word valid
//   out_ready_i : consumer accepts the word
//   master = scheduler side, slave = consumer side.
interface fifo_rd_sched_if;
  import fifo_rd_sched_pkg::*;

  logic [DAT_W-1:0] out_dat_o;
  logic [CH_W-1:0]  out_ch_o;
  logic             out_first_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport master (
    output out_dat_o, out_ch_o, out_first_o, out_valid_o,
    input  out_ready_i
  );

  modport slave (
    input  out_dat_o, out_ch_o, out_first_o, out_valid_o,
    output out_ready_i
  );

endinterface

// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb
//   Combinational round-robin arbiter over the FIFO channels.
//   req    : per-channel request
//   last   : previously granted channel; search starts at last+1 (mod N_CH)
//   winner : granted channel (meaningful only when hit=1)
//   hit    : at least one request present
module fifo_rr_arb
  import fifo_rd_sched_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic [CH_W-1:0] winner,
  output logic            hit
);

  // CH_W-bit addition wraps naturally modulo N_CH; i = N_CH lands on last.
  always_comb begin
    winner = last;
    hit    = 1'b0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      if (!hit && req[last + CH_W'(i)]) begin
        winner = last + CH_W'(i);
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// fifo_rd_sched
//   Read-side scheduler for the shared 8-channel FIFO (B-side clock domain).
//   Grants a non-empty enabled channel round-robin, reads up to BURST_LEN
//   words from it, and forwards the words with channel/first tags through
//   an OBUF_DEPTH-entry output buffer onto a valid/ready stream.
//   clk, rst_n   : clock, synchronous active-low reset
//   ch_en_i      : per-channel enable
//   fifo_empty_i : per-channel FIFO empty flags
//   fifo_sel_o   : FIFO read channel select
//   fifo_re_o    : FIFO read enable (data returns the next cycle)
//   fifo_dat_i   : FIFO read data
//   stream       : output stream (out_dat_o/out_ch_o/out_first_o/out_valid_o/out_ready_i)
//   busy_o       : bursting, words buffered, or a read in flight
module fifo_rd_sched
  import fifo_rd_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
  parameter int unsigned OBUF_DEPTH = OBUF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_en_i,
  input  logic [N_CH-1:0]        fifo_empty_i,
  output logic [CH_W-1:0]        fifo_sel_o,
  output logic                   fifo_re_o,
  input  logic [DAT_W-1:0]       fifo_dat_i,
  fifo_rd_sched_if.master        stream,
  output logic                   busy_o
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(OBUF_DEPTH + 1);

  state_t            state;
  logic [CH_W-1:0]   sel_q;
  logic [CH_W-1:0]   last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              inflight_q;
  rd_tag_t           tag_q;

  obuf_ent_t         mem [OBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ_q;

  logic [N_CH-1:0]   req;
  logic [CH_W-1:0]   win;
  logic              hit;
  logic              sel_ok;
  logic              burst_done;
  logic              space_ok;
  logic              rd_en;
  logic              push;
  logic              pop;

  assign req = ~fifo_empty_i & ch_en_i;

  fifo_rr_arb u_arb (
    .req    (req),
    .last   (last_q),
    .winner (win),
    .hit    (hit)
  );

  assign sel_ok     = !fifo_empty_i[sel_q] && ch_en_i[sel_q];
  assign burst_done = (cnt_q == CNT_W'(BURST_LEN));
  // In-flight read is counted so a word returning under backpressure
  // always has a slot waiting for it.
  assign space_ok   = ({1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q})
                      < (OCC_W + 1)'(OBUF_DEPTH);

  // Read enable is decoded from registered state but gated by the live
  // empty/enable flags, so a channel is never read in a cycle its flag is high.
  assign rd_en      = (state == S_BURST) && sel_ok && !burst_done && space_ok;

  assign fifo_re_o  = rd_en;
  assign fifo_sel_o = sel_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sel_q      <= '0;
      last_q     <= CH_W'(N_CH - 1);
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        tag_q <= '{ch: sel_q, first: (cnt_q == '0)};
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (hit) begin
            sel_q <= win;
            cnt_q <= '0;
            state <= S_BURST;
          end
        end
        S_BURST: begin
          // A buffer-space stall alone keeps the grant.
          if (burst_done || !sel_ok) begin
            last_q <= sel_q;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = inflight_q;
  assign pop  = stream.out_valid_o && stream.out_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{dat: fifo_dat_i, ch: tag_q.ch, first: tag_q.first};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign stream.out_valid_o = (occ_q != '0);
  assign stream.out_dat_o   = mem[rd_ptr].dat;
  assign stream.out_ch_o    = mem[rd_ptr].ch;
  assign stream.out_first_o = mem[rd_ptr].first;

  assign busy_o = (state != S_IDLE) || (occ_q != '0) || inflight_q;

endmodule
